// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid buffer, flush and stall counter.
// Latency: an accepted DI word appears on DO with OUT_VALID=1 one cycle later; sustains 1 word per cycle.
// Backpressure: SKID=1 uses a registered IN_READY that drops only when both entries are full; SKID=0 uses IN_READY = !OUT_VALID | OUT_READY.
//
// Ports:
//   CLK        rising-edge clock
//   RESET      asynchronous, active-high reset
//   FLUSH      synchronous flush; drops all held data and the word offered this cycle
//   IN_VALID   upstream has a word on DI
//   IN_READY   stage can accept DI this cycle
//   DI         upstream payload
//   OUT_VALID  DO holds a valid word
//   OUT_READY  downstream takes DO this cycle
//   DO         payload to downstream, always driven from the main register
//   STALL_CNT  saturating count of cycles with OUT_VALID=1 and OUT_READY=0
module pipe_stage_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SKID      = 1'b1,
    parameter int               CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] DI,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] DO,
    output logic [CNT_W-1:0] STALL_CNT
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = IN_VALID & IN_READY;
    assign out_xfer = OUT_VALID & OUT_READY;

    // Flush cycles are not counted as stalls; the counter survives a flush.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            STALL_CNT <= '0;
        end else if (OUT_VALID && !OUT_READY && !FLUSH && (STALL_CNT != CNT_MAX)) begin
            STALL_CNT <= STALL_CNT + CNT_W'(1);
        end
    end

    generate
        if (SKID) begin : g_skid
            state_t           state_q;
            logic [WIDTH-1:0] main_q;
            logic [WIDTH-1:0] skid_q;
            logic             rdy_q;

            // rdy_q tracks (state != TWO) as its own flop so IN_READY never
            // depends combinationally on OUT_READY.
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    state_q <= ST_EMPTY;
                    main_q  <= RESET_VAL;
                    skid_q  <= '0;
                    rdy_q   <= 1'b1;
                end else if (FLUSH) begin
                    state_q <= ST_EMPTY;
                    main_q  <= RESET_VAL;
                    skid_q  <= '0;
                    rdy_q   <= 1'b1;
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            if (in_xfer) begin
                                main_q  <= DI;
                                state_q <= ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (in_xfer && out_xfer) begin
                                main_q <= DI;
                            end else if (in_xfer) begin
                                // Downstream stalled: park the new word behind main.
                                skid_q  <= DI;
                                state_q <= ST_TWO;
                                rdy_q   <= 1'b0;
                            end else if (out_xfer) begin
                                state_q <= ST_EMPTY;
                            end
                        end
                        ST_TWO: begin
                            if (out_xfer) begin
                                main_q  <= skid_q;
                                state_q <= ST_ONE;
                                rdy_q   <= 1'b1;
                            end
                        end
                        default: begin
                            state_q <= ST_EMPTY;
                            rdy_q   <= 1'b1;
                        end
                    endcase
                end
            end

            assign IN_READY  = rdy_q;
            assign OUT_VALID = (state_q != ST_EMPTY);
            assign DO        = main_q;
        end else begin : g_single
            logic [WIDTH-1:0] main_q;
            logic             vld_q;

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    main_q <= RESET_VAL;
                    vld_q  <= 1'b0;
                end else if (FLUSH) begin
                    main_q <= RESET_VAL;
                    vld_q  <= 1'b0;
                end else if (in_xfer) begin
                    main_q <= DI;
                    vld_q  <= 1'b1;
                end else if (out_xfer) begin
                    vld_q  <= 1'b0;
                end
            end

            assign IN_READY  = !vld_q || OUT_READY;
            assign OUT_VALID = vld_q;
            assign DO        = main_q;
        end
    endgenerate

endmodule
